// File: rtl/stitch_shell_pkg.sv
// Shared types and width helpers for the stitched-pipeline receive shell.
package stitch_shell_pkg;

  localparam int RESULT_W_DEF = 32;

  typedef logic [RESULT_W_DEF-1:0] result_t;

  // Count registers must hold 0..DEPTH inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stitch_result_fifo.sv
// Synchronous result FIFO: head read from registered storage, wrap-around pointers
// for any DEPTH, sticky overflow when a push hits a full queue with no pop.
module stitch_result_fifo
  import stitch_shell_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              pop_ok, push_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign pop_ok     = pop_i && !empty_o;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

  always_comb begin
    rd_ptr_d   = pop_ok  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
    count_d    = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | (push_i && !push_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/stitch_pipeline_output_receiver.sv
// Receive shell for a clk-only stitched pipeline: credit admission, valid tracking
// matched to pipeline latency, and an elastic result FIFO with ready/valid output.
module stitch_pipeline_output_receiver
  import stitch_shell_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic                         pipe_launch_o,
  input  logic [DATA_W-1:0]            pipe_out_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_W-1:0]            out_data_o,
  output logic [occ_width(DEPTH)-1:0]  occupancy_o,
  output logic                         overflow_err_o
);

  localparam int CNT_W = occ_width(DEPTH);
  localparam int CRD_W = credit_width(DEPTH);

  logic [CRD_W-1:0]   credits_q, credits_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;

  // Ready depends only on registered credits, never on out_ready or in_valid.
  assign in_ready_o    = (credits_q != '0);
  assign pipe_launch_o = in_valid_i && in_ready_o;
  assign out_valid_o   = !fifo_empty;
  assign pop           = out_valid_o && out_ready_i;

  always_comb begin
    credits_d = credits_q;
    case ({pipe_launch_o, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = (credits_q == CRD_W'(DEPTH)) ? credits_q : credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
    vld_d    = vld_q << 1;
    vld_d[0] = pipe_launch_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CRD_W'(DEPTH);
      vld_q     <= '0;
    end else begin
      credits_q <= credits_d;
      vld_q     <= vld_d;
    end
  end

  stitch_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (vld_q[LATENCY-1]),
    .push_data_i (pipe_out_i),
    .pop_i       (out_ready_i),
    .head_o      (out_data_o),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (occupancy_o),
    .overflow_o  (overflow_err_o)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
